// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_result_e;

  // Ceiling log2; clog2(1) is 0, so callers wanting a usable width clamp to 1.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational unsigned compare of one chunk. Flipping the top bit of
// both operands turns a two's-complement compare into an unsigned one.
module chunk_compare
  import cmp_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             msb_invert,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  logic [CHUNK-1:0] mask;
  logic [CHUNK-1:0] xa;
  logic [CHUNK-1:0] xb;

  // Bias the sign bit when this chunk carries the operand sign, then compare.
  always_comb begin
    mask             = '0;
    mask[CHUNK-1]    = msb_invert;
    xa               = a ^ mask;
    xb               = b ^ mask;
    gt               = (xa > xb);
    lt               = (xa < xb);
    eq               = (xa == xb);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per
// cycle from the MSB end, optionally stopping at the first difference.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  input  logic                                 is_signed,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 greater,
  output logic                                 less,
  output logic                                 equal,
  output logic [clog2(WIDTH/CHUNK+1)-1:0]      out_cycles
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = clog2(NCHUNK + 1);
  localparam int IDXW   = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("seq_magnitude_comparator: WIDTH must be a multiple of CHUNK");
  end

  cmp_state_e       state;
  cmp_state_e       next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             sgn;
  logic [IDXW-1:0]  idx;
  logic [CW-1:0]    cnt;
  cmp_result_e      res;
  logic             found;
  logic             chunk_gt;
  logic             chunk_lt;
  logic             chunk_eq;
  logic             msb_inv;
  logic             last_chunk;
  logic             done_hold;

  assign in_ready   = (state == IDLE);
  assign last_chunk = (idx == IDXW'(0));
  assign msb_inv    = sgn && (idx == IDXW'(NCHUNK - 1));
  assign done_hold  = (state == DONE) && (next_state == DONE);

  chunk_compare #(.CHUNK(CHUNK)) u_chunk (
    .a          (a_sh[WIDTH-1 -: CHUNK]),
    .b          (b_sh[WIDTH-1 -: CHUNK]),
    .msb_invert (msb_inv),
    .gt         (chunk_gt),
    .lt         (chunk_lt),
    .eq         (chunk_eq)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; a fresh difference or the last chunk ends the scan.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (!found && !chunk_eq && (EARLY_EXIT != 0)) begin
          next_state = DONE;
        end else if (last_chunk) begin
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand shifters, chunk index, cycle counter and sticky result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sgn   <= 1'b0;
      idx   <= '0;
      cnt   <= '0;
      res   <= CMP_EQ;
      found <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            sgn   <= is_signed;
            idx   <= IDXW'(NCHUNK - 1);
            cnt   <= '0;
            res   <= CMP_EQ;
            found <= 1'b0;
          end
        end
        RUN: begin
          cnt  <= cnt + CW'(1);
          a_sh <= a_sh << CHUNK;
          b_sh <= b_sh << CHUNK;
          if (!last_chunk) begin
            idx <= idx - IDXW'(1);
          end
          if (!found && !chunk_eq) begin
            res   <= chunk_gt ? CMP_GT : CMP_LT;
            found <= 1'b1;
          end
        end
        default: begin
          found <= found;
        end
      endcase
    end
  end

  // Registered result outputs; live only while the result is being offered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      greater    <= 1'b0;
      less       <= 1'b0;
      equal      <= 1'b0;
      out_cycles <= '0;
    end else begin
      out_valid  <= done_hold;
      greater    <= done_hold && (res == CMP_GT);
      less       <= done_hold && (res == CMP_LT);
      equal      <= done_hold && (res == CMP_EQ);
      out_cycles <= done_hold ? cnt : '0;
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench: main instance (16/4, early exit), a full-scan instance
// and a single-chunk instance share the same stimulus.
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        is_signed = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;

  logic       in_ready, out_valid, greater, less, equal;
  logic [2:0] out_cycles;
  logic       ne_in_ready, ne_out_valid, ne_greater, ne_less, ne_equal;
  logic [2:0] ne_out_cycles;
  logic       w_in_ready, w_out_valid, w_greater, w_less, w_equal;
  logic [0:0] w_out_cycles;

  int errors = 0;
  int checks = 0;

  int       ne_cnt = 0;
  logic [2:0] ne_res = 3'b000;
  int       ne_k = 0;
  int       w_cnt = 0;
  logic [2:0] w_res = 3'b000;
  int       w_k = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .greater(greater), .less(less), .equal(equal),
    .out_cycles(out_cycles)
  );

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) dut_ne (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ne_in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(ne_out_valid),
    .out_ready(out_ready), .greater(ne_greater), .less(ne_less), .equal(ne_equal),
    .out_cycles(ne_out_cycles)
  );

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(16), .EARLY_EXIT(1)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(w_out_valid),
    .out_ready(out_ready), .greater(w_greater), .less(w_less), .equal(w_equal),
    .out_cycles(w_out_cycles)
  );

  // Capture the most recent result offered by the secondary instances.
  always @(negedge clk) begin
    if (ne_out_valid && out_ready) begin
      ne_cnt <= ne_cnt + 1;
      ne_res <= {ne_greater, ne_less, ne_equal};
      ne_k   <= int'(ne_out_cycles);
    end
    if (w_out_valid && out_ready) begin
      w_cnt <= w_cnt + 1;
      w_res <= {w_greater, w_less, w_equal};
      w_k   <= int'(w_out_cycles);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_all_idle(input string tag);
    int n;
    n = 0;
    while (!(in_ready && ne_in_ready && w_in_ready) && n < 60) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    check({tag, "_idle"}, {31'd0, in_ready && ne_in_ready && w_in_ready}, 32'd1);
  endtask

  // Wait from just after the accept edge until out_valid; returns edges counted.
  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n = n + 1;
    end
  endtask

  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic sg);
    @(posedge clk); #1;
    a = av; b = bv; is_signed = sg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic sg, input logic [2:0] exp_res, input int exp_k,
                        input logic [2:0] exp_ne_res, input logic [2:0] exp_w_res);
    int n;
    int ne0;
    int w0;
    wait_all_idle({tag, "_pre"});
    ne0 = ne_cnt;
    w0  = w_cnt;
    start_op(av, bv, sg);
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_flags_run"}, {29'd0, greater, less, equal}, 32'd0);
    wait_result(n);
    check({tag, "_lat"}, n, exp_k + 1);
    check({tag, "_res"}, {29'd0, greater, less, equal}, {29'd0, exp_res});
    check({tag, "_k"}, {29'd0, out_cycles}, exp_k);
    wait_all_idle(tag);
    check({tag, "_ne_cnt"}, ne_cnt - ne0, 32'd1);
    check({tag, "_ne_res"}, {29'd0, ne_res}, {29'd0, exp_ne_res});
    check({tag, "_ne_k"}, ne_k, 32'd4);
    check({tag, "_w_cnt"}, w_cnt - w0, 32'd1);
    check({tag, "_w_res"}, {29'd0, w_res}, {29'd0, exp_w_res});
    check({tag, "_w_k"}, w_k, 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;
    // Reset state
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_flags", {29'd0, greater, less, equal}, 32'd0);
    check("rst_cycles", {29'd0, out_cycles}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Result codes are {greater, less, equal}
    run_op("eq_1234",  16'h1234, 16'h1234, 1'b0, 3'b001, 4, 3'b001, 3'b001);
    run_op("u_8000",   16'h8000, 16'h7FFF, 1'b0, 3'b100, 1, 3'b100, 3'b100);
    run_op("s_8000",   16'h8000, 16'h7FFF, 1'b1, 3'b010, 1, 3'b010, 3'b010);
    run_op("u_12a4",   16'h12A4, 16'h12B4, 1'b0, 3'b010, 3, 3'b010, 3'b010);
    run_op("s_ffff",   16'hFFFF, 16'h0001, 1'b1, 3'b010, 1, 3'b010, 3'b010);
    run_op("s_minneg", 16'h8000, 16'h0000, 1'b1, 3'b010, 1, 3'b010, 3'b010);
    run_op("s_maxpos", 16'h7FFF, 16'h8000, 1'b1, 3'b100, 1, 3'b100, 3'b100);
    run_op("u_last",   16'h0001, 16'h0002, 1'b0, 3'b010, 4, 3'b010, 3'b010);
    run_op("s_eqneg",  16'h8000, 16'h8000, 1'b1, 3'b001, 4, 3'b001, 3'b001);

    // Backpressure: result held while out_ready is low, new pair waits
    wait_all_idle("bp_pre");
    out_ready = 1'b0;
    start_op(16'h12A4, 16'h12B4, 1'b0);
    wait_result(n);
    check("bp_lat", n, 32'd4);
    a = 16'h5000; b = 16'h4000; is_signed = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_res", {29'd0, greater, less, equal}, 32'd2);
      check("bp_hold_k", {29'd0, out_cycles}, 32'd3);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    check("bp_hs_flags", {29'd0, greater, less, equal}, 32'd0);
    check("bp_hs_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("bp_accept", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_result(n);
    check("bp_new_lat", n, 32'd2);
    check("bp_new_res", {29'd0, greater, less, equal}, 32'd4);
    check("bp_new_k", {29'd0, out_cycles}, 32'd1);
    wait_all_idle("bp_post");

    // Reset in the middle of a scan
    start_op(16'h1234, 16'h1234, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_flags", {29'd0, greater, less, equal}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_cycles", {29'd0, out_cycles}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid || ne_out_valid || w_out_valid) seen = seen + 1;
    end
    check("mrst_no_result", seen, 32'd0);
    run_op("post_rst", 16'hA5A5, 16'hA5A4, 1'b0, 3'b100, 4, 3'b100, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
